// File: rtl/half_store_unit.sv
// rtl/half_store_unit.sv - sw/sh store unit with read-modify-write for half-word stores
//
// Purpose: accepts sw/sh store requests from the MEM stage and writes a 32-bit
// word RAM. Full-word stores write directly; half-word stores read the word,
// merge the 16-bit half into the lane chosen by address bit 1, then write back.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready request handshake (ready only in IDLE)
//   req_half            1 = sh, 0 = sw
//   req_addr/req_data   byte address and store data (sh uses [15:0])
//   stall               ~req_ready, holds the pipeline
//   mem_addr            word address to RAM (0 while idle)
//   mem_re/mem_rdata    RAM read strobe, data valid the cycle after
//   mem_we/mem_wdata    RAM 32-bit write strobe and data
//   done                pulses with mem_we
//   err                 pulses the cycle after a misaligned request
module half_store_unit #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_half,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_data,
   output logic              stall,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   input  logic [31:0]       mem_rdata,
   output logic              mem_we,
   output logic [31:0]       mem_wdata,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_WAIT = 3'd2,
      S_MRG  = 3'd3,
      S_WR   = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:1]   addr_q;
   logic [15:0]         half_q;
   logic [31:0]         wdata_q;
   logic                err_q;

   logic                accept;
   logic                aligned;

   // Requests are only looked at in IDLE; anything presented while busy is ignored.
   assign accept  = (state_q == S_IDLE) && req_valid;
   assign aligned = req_half ? ~req_addr[0] : (req_addr[1:0] == 2'b00);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid && aligned) begin
               state_d = req_half ? S_RD : S_WR;
            end
         end
         S_RD:    state_d = S_WAIT;
         S_WAIT:  state_d = S_MRG;
         S_MRG:   state_d = S_WR;
         S_WR:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath registers. Byte 0 of the address is never needed after the
   // alignment check, so only bits [ADDR_W-1:1] are kept.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= '0;
         half_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         err_q <= accept && !aligned;
         if (accept && aligned) begin
            addr_q <= req_addr[ADDR_W-1:1];
            half_q <= req_data[15:0];
            if (!req_half) begin
               wdata_q <= req_data;
            end
         end
         // Read data is valid in WAIT; merge the new half into the lane
         // selected by address bit 1 and keep the other half from RAM.
         if (state_q == S_WAIT) begin
            if (addr_q[1]) begin
               wdata_q <= {half_q, mem_rdata[15:0]};
            end else begin
               wdata_q <= {mem_rdata[31:16], half_q};
            end
         end
      end
   end

   // Output decode from the state register only
   always_comb begin
      req_ready = 1'b0;
      stall     = 1'b1;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      done      = 1'b0;
      mem_wdata = '0;
      mem_addr  = '0;
      err       = err_q;
      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            stall     = 1'b0;
         end
         S_RD: begin
            mem_re = 1'b1;
         end
         S_WR: begin
            mem_we    = 1'b1;
            done      = 1'b1;
            mem_wdata = wdata_q;
         end
         default: begin
         end
      endcase
      if (state_q != S_IDLE) begin
         mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
      end
   end

endmodule

// File: tb/tb_half_store_unit.sv
// tb/tb_half_store_unit.sv - table-driven bench for half_store_unit
module tb_half_store_unit;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_half;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic        stall;
   logic [31:0] mem_addr;
   logic        mem_re;
   logic [31:0] mem_rdata;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic        done;
   logic        err;

   int n_checks;
   int n_fail;

   half_store_unit #(.ADDR_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_half  (req_half),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .stall     (stall),
      .mem_addr  (mem_addr),
      .mem_re    (mem_re),
      .mem_rdata (mem_rdata),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .done      (done),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word RAM: synchronous read (data the cycle after mem_re), plus a bench preload port.
   logic [31:0] ram [0:255];
   logic        ram_clr;
   logic        pre_we;
   logic [7:0]  pre_idx;
   logic [31:0] pre_data;

   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
         mem_rdata <= 32'h0;
      end else begin
         if (pre_we) ram[pre_idx] <= pre_data;
         else if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;
         if (mem_re) mem_rdata <= ram[mem_addr[9:2]];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [31:0] addr, input logic [31:0] val);
      pre_we   = 1'b1;
      pre_idx  = addr[9:2];
      pre_data = val;
      @(negedge clk);
      pre_we   = 1'b0;
   endtask

   task automatic drive_req(input logic half, input logic [31:0] addr, input logic [31:0] data);
      req_valid = 1'b1;
      req_half  = half;
      req_addr  = addr;
      req_data  = data;
   endtask

   typedef struct {
      logic        half;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] init;
      logic [31:0] exp_wdata;
      logic [31:0] exp_ram;
      int          exp_re;
      int          exp_we;
      int          exp_err;
      int          exp_rdy;
   } vec_t;

   vec_t vecs [7];

   initial begin
      int re_c, we_c, err_c, rdy_c, n_we, n_re, n_err, done_bad, acc;
      logic [31:0] wd, ma;

      n_checks  = 0;
      n_fail    = 0;
      rst       = 1'b1;
      ram_clr   = 1'b1;
      pre_we    = 1'b0;
      pre_idx   = 8'h0;
      pre_data  = 32'h0;
      req_valid = 1'b0;
      req_half  = 1'b0;
      req_addr  = 32'h0;
      req_data  = 32'h0;

      //          half  addr          data          init          exp_wdata     exp_ram       re we err rdy
      vecs[0] = '{1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 1, 0, 2};
      vecs[1] = '{1'b1, 32'h0000_0106, 32'hFFFF_ABCD, 32'h1122_3344, 32'hABCD_3344, 32'hABCD_3344, 1, 4, 0, 5};
      vecs[2] = '{1'b1, 32'h0000_0104, 32'hFFFF_ABCD, 32'h1122_3344, 32'h1122_ABCD, 32'h1122_ABCD, 1, 4, 0, 5};
      vecs[3] = '{1'b1, 32'h0000_0103, 32'h0000_5555, 32'h7777_8888, 32'h0000_0000, 32'h7777_8888, 0, 0, 1, 1};
      vecs[4] = '{1'b0, 32'h0000_0102, 32'h1234_5678, 32'h7777_8888, 32'h0000_0000, 32'h7777_8888, 0, 0, 1, 1};
      vecs[5] = '{1'b1, 32'h0000_010A, 32'h0000_8001, 32'hCAFE_F00D, 32'h8001_F00D, 32'h8001_F00D, 1, 4, 0, 5};
      vecs[6] = '{1'b0, 32'h0000_01FC, 32'h0123_4567, 32'hFFFF_FFFF, 32'h0123_4567, 32'h0123_4567, 0, 1, 0, 2};

      // Reset, then idle for 3 cycles
      @(negedge clk);
      @(negedge clk);
      rst     = 1'b0;
      ram_clr = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("rst_ready",  {31'b0, req_ready}, 32'h1);
         check("rst_stall",  {31'b0, stall},     32'h0);
         check("rst_we",     {31'b0, mem_we},    32'h0);
         check("rst_re",     {31'b0, mem_re},    32'h0);
         check("rst_done",   {31'b0, done},      32'h0);
         check("rst_err",    {31'b0, err},       32'h0);
         check("rst_maddr",  mem_addr,           32'h0);
         check("rst_wdata",  mem_wdata,          32'h0);
      end

      // Table-driven single requests
      for (int v = 0; v < 7; v++) begin
         preload(vecs[v].addr, vecs[v].init);
         check($sformatf("v%0d_ready_pre", v), {31'b0, req_ready}, 32'h1);
         drive_req(vecs[v].half, vecs[v].addr, vecs[v].data);
         @(negedge clk);
         req_valid = 1'b0;
         re_c = 0; we_c = 0; err_c = 0; rdy_c = 0;
         n_we = 0; n_re = 0; n_err = 0; done_bad = 0;
         wd = 32'h0; ma = 32'h0;
         for (int k = 1; k <= 6; k++) begin
            if (mem_re) begin
               n_re++;
               if (re_c == 0) re_c = k;
            end
            if (mem_we) begin
               n_we++;
               if (we_c == 0) begin
                  we_c = k;
                  wd   = mem_wdata;
                  ma   = mem_addr;
               end
            end
            if (err) begin
               n_err++;
               if (err_c == 0) err_c = k;
            end
            if (req_ready && rdy_c == 0) rdy_c = k;
            if (done !== mem_we) done_bad++;
            @(negedge clk);
         end
         check($sformatf("v%0d_re_cycle", v),  re_c,  vecs[v].exp_re);
         check($sformatf("v%0d_re_count", v),  n_re,  (vecs[v].exp_re != 0) ? 1 : 0);
         check($sformatf("v%0d_we_cycle", v),  we_c,  vecs[v].exp_we);
         check($sformatf("v%0d_we_count", v),  n_we,  (vecs[v].exp_we != 0) ? 1 : 0);
         check($sformatf("v%0d_err_cycle", v), err_c, vecs[v].exp_err);
         check($sformatf("v%0d_err_count", v), n_err, (vecs[v].exp_err != 0) ? 1 : 0);
         check($sformatf("v%0d_rdy_cycle", v), rdy_c, vecs[v].exp_rdy);
         check($sformatf("v%0d_done_we", v),   done_bad, 0);
         if (vecs[v].exp_we != 0) begin
            check($sformatf("v%0d_wdata", v), wd, vecs[v].exp_wdata);
            check($sformatf("v%0d_maddr", v), ma, vecs[v].addr & 32'hFFFF_FFFC);
         end
         check($sformatf("v%0d_ram", v), ram[vecs[v].addr[9:2]], vecs[v].exp_ram);
      end

      // Back-to-back sh to the same word; requester holds the second request
      preload(32'h200, 32'h0);
      drive_req(1'b1, 32'h200, 32'h0000_AAAA);
      @(negedge clk);
      drive_req(1'b1, 32'h202, 32'h0000_BBBB);
      acc = 0;
      for (int k = 1; k <= 20; k++) begin
         if (req_ready) begin
            acc = k;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      req_valid = 1'b0;
      repeat (6) @(negedge clk);
      check("b2b_accept_cycle", acc, 5);
      check("b2b_ram", ram[8'h80], 32'hBBBB_AAAA);

      // Reset during WAIT abandons the RMW
      preload(32'h300, 32'h5566_7788);
      drive_req(1'b1, 32'h300, 32'h0000_1234);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("wrst_ready", {31'b0, req_ready}, 32'h1);
      check("wrst_maddr", mem_addr, 32'h0);
      n_we = 0;
      for (int k = 0; k < 6; k++) begin
         if (mem_we) n_we++;
         @(negedge clk);
      end
      check("wrst_no_we", n_we, 0);
      check("wrst_ram", ram[8'hC0], 32'h5566_7788);

      // Request presented together with reset is dropped
      preload(32'h3F0, 32'h0BAD_F00D);
      rst = 1'b1;
      drive_req(1'b0, 32'h3F0, 32'h0000_0099);
      @(negedge clk);
      rst       = 1'b0;
      req_valid = 1'b0;
      n_we = 0;
      for (int k = 0; k < 4; k++) begin
         if (mem_we) n_we++;
         @(negedge clk);
      end
      check("rstreq_no_we", n_we, 0);
      check("rstreq_ram", ram[8'hFC], 32'h0BAD_F00D);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
